axi_lite_cmd_launcher: RTL and testbench
========================================

// Module: axi_lite_cmd_launcher
// PURPOSE
//   Upstream front end for the AXI-Lite master on the board top. Synchronises and debounces the
//   board switches, turns each debounced rising edge of the enable switch into exactly one
//   read/write command to the master, waits for its response, and holds the low byte of the
//   last good read for the LEDs. Gives one transaction per switch flip, with no repeats while held.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles to accept a new enable level (10 ms @ 100 MHz)
//   ADDR_W           5          command address width
//   DATA_W           32         write/read data width
// PORTS
//   aclk          in   1       system clock
//   aresetn       in   1       asynchronous active-low reset
//   sw_enable     in   1       raw enable switch (async to aclk, bouncy)
//   sw_rw         in   1       raw direction switch: 1 = write, 0 = read
//   sw_addr       in   ADDR_W  raw address switches
//   wr_data_in    in   DATA_W  write payload (static in system)
//   cmd_valid     out  1       command offered to master
//   cmd_ready     in   1       master accepts command
//   cmd_write     out  1       captured direction
//   cmd_addr      out  ADDR_W  captured address
//   cmd_wdata     out  DATA_W  captured write data
//   resp_valid    in   1       single-cycle response pulse from master
//   resp_code     in   2       AXI response (00 = OKAY)
//   resp_rdata    in   DATA_W  read data, valid with resp_valid
//   busy          out  1       FSM not IDLE
//   led_data      out  8       resp_rdata[7:0] of last OKAY read
//   err_sticky    out  1       set on any non-OKAY response, cleared only by reset
// BEHAVIOUR
//   Reset (async assert, sync release): cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, busy=0,
//     led_data=0, err_sticky=0, sync flops=0, debounced level=0, counter=0, FSM=IDLE.
//   Sync: sw_enable, sw_rw, sw_addr each pass through 2 flops before any use.
//   Debounce: counter clears whenever synced enable == debounced level; otherwise it increments.
//     When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and
//     the counter clears. Glitches shorter than DEBOUNCE_CYCLES never change the level.
//   Edge: launch = debounced level 0->1 (registered compare). Falling edges do nothing.
//   A switch held high through reset release yields one launch after debounce.
//   FSM:
//     IDLE: on launch, capture synced sw_rw/sw_addr and wr_data_in into cmd_*, then go to ISSUE.
//     ISSUE: cmd_valid=1. cmd_* hold stable until cmd_valid & cmd_ready. On that cycle go to WAIT;
//       cmd_valid is 0 from the next cycle.
//     WAIT: on resp_valid, go to IDLE. If !cmd_write and resp_code==00, led_data <= resp_rdata[7:0].
//       If resp_code!=00, err_sticky <= 1 and led_data is unchanged. Writes never touch led_data.
//   Latency: cmd_valid rises on the cycle after launch; IDLE is re-entered the cycle after resp_valid.
//   Launches in ISSUE/WAIT are dropped, not queued. resp_valid outside WAIT is ignored.
//   cmd_valid & cmd_ready on the same cycle as resp_valid (impossible per protocol) is handled
//     as ISSUE->WAIT only.
//   busy = (state != IDLE), registered. Reset mid-transaction aborts at once: cmd_valid drops
//     asynchronously and no LED/err update occurs.
// TESTING (bench DEBOUNCE_CYCLES=4)
//   1. Enable bounce pattern 1,0,1,0 (1 cycle each), then steady 1 -> exactly one cmd_valid, 2+4+1
//      cycles after steady.
//   2. sw_rw=0, sw_addr=5'h03, launch; cmd_ready 2 cycles late; resp OKAY rdata=32'hDEADBEEF
//      -> cmd_addr=3 stable while waiting, led_data=8'hEF.
//   3. sw_rw=1, addr=5'h1F, launch, resp OKAY -> cmd_wdata=wr_data_in, led_data unchanged.
//   4. Read with resp_code=2'b10 -> err_sticky=1, led_data keeps previous value; a second OKAY read
//      keeps err_sticky=1.
//   5. Toggle enable 0->1 while in WAIT -> no second command; after resp, IDLE with no launch.
//   6. Assert aresetn=0 during ISSUE -> cmd_valid=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/axi_lite_cmd_launcher_if.sv
// Command/response channel between the switch-driven launcher and the AXI-Lite master.
// The launcher offers a command with a valid/ready handshake. The master returns a
// single-cycle response pulse.
interface axi_lite_cmd_launcher_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              resp_valid;
   logic [1:0]        resp_code;
   logic [DATA_W-1:0] resp_rdata;

   // Launcher side: issues commands and consumes responses.
   modport master (
      output cmd_valid,
      output cmd_write,
      output cmd_addr,
      output cmd_wdata,
      input  cmd_ready,
      input  resp_valid,
      input  resp_code,
      input  resp_rdata
   );

   // AXI-Lite master side: accepts commands and produces responses.
   modport slave (
      input  cmd_valid,
      input  cmd_write,
      input  cmd_addr,
      input  cmd_wdata,
      output cmd_ready,
      output resp_valid,
      output resp_code,
      output resp_rdata
   );

endinterface

// File: rtl/axi_lite_cmd_launcher.sv
// Switch-driven command launcher for the board-level AXI-Lite master.
// The block synchronises and debounces the board switches. Each debounced rising edge of the
// enable switch becomes exactly one read or write command. The block then waits for the
// response and keeps the low byte of the last good read for the LEDs.
module axi_lite_cmd_launcher #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned ADDR_W          = 5,
   parameter int unsigned DATA_W          = 32
) (
   input  logic                           aclk,
   input  logic                           aresetn,

   input  logic                           sw_enable,
   input  logic                           sw_rw,
   input  logic [ADDR_W-1:0]              sw_addr,
   input  logic [DATA_W-1:0]              wr_data_in,

   axi_lite_cmd_launcher_if.master        cmd_bus,

   output logic                           busy,
   output logic [7:0]                     led_data,
   output logic                           err_sticky
);

   // A counter of this width can hold DEBOUNCE_CYCLES-1. At least one bit is kept so that
   // DEBOUNCE_CYCLES=1 still elaborates.
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   // ---------------------------------------------------------------------------------------
   // Switch synchronisers
   // ---------------------------------------------------------------------------------------
   logic              en_meta_q,   en_sync_q;
   logic              rw_meta_q,   rw_sync_q;
   logic [ADDR_W-1:0] addr_meta_q, addr_sync_q;

   // Two-flop synchronisers. The switches are quasi-static, so per-bit sync of the address
   // is acceptable.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         en_meta_q   <= 1'b0;
         en_sync_q   <= 1'b0;
         rw_meta_q   <= 1'b0;
         rw_sync_q   <= 1'b0;
         addr_meta_q <= '0;
         addr_sync_q <= '0;
      end else begin
         en_meta_q   <= sw_enable;
         en_sync_q   <= en_meta_q;
         rw_meta_q   <= sw_rw;
         rw_sync_q   <= rw_meta_q;
         addr_meta_q <= sw_addr;
         addr_sync_q <= addr_meta_q;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Enable debounce and edge detect
   // ---------------------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             db_prev_q;
   logic             launch;

   // The counter runs only while the synced level disagrees with the accepted level. A run
   // of DEBOUNCE_CYCLES disagreeing cycles flips the level. Any agreeing cycle restarts it.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (en_sync_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = en_sync_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state and the previous debounced level used for edge detection.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
      end
   end

   // Only a 0->1 change of the debounced level starts a command. Falling edges are ignored.
   assign launch = db_q & ~db_prev_q;

   // ---------------------------------------------------------------------------------------
   // Command FSM
   // ---------------------------------------------------------------------------------------
   state_e state_q, state_d;
   logic   capture;
   logic   resp_take;

   // Next-state logic. A launch seen outside IDLE is dropped, and a response seen outside
   // WAIT is ignored.
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      resp_take = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (launch) begin
               capture = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // A response arriving in the handshake cycle is not honoured here. Only the
            // move to WAIT happens.
            if (cmd_bus.cmd_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (cmd_bus.resp_valid) begin
               resp_take = 1'b1;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM state register. The async reset aborts any transaction immediately.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Captured command fields
   // ---------------------------------------------------------------------------------------
   logic              cmd_write_q;
   logic [ADDR_W-1:0] cmd_addr_q;
   logic [DATA_W-1:0] cmd_wdata_q;

   // Fields are latched once at launch and held through ISSUE and WAIT.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
      end else if (capture) begin
         cmd_write_q <= rw_sync_q;
         cmd_addr_q  <= addr_sync_q;
         cmd_wdata_q <= wr_data_in;
      end
   end

   // cmd_valid comes straight from the state flop. The async reset therefore drops it in
   // the same cycle.
   assign cmd_bus.cmd_valid = (state_q == StIssue);
   assign cmd_bus.cmd_write = cmd_write_q;
   assign cmd_bus.cmd_addr  = cmd_addr_q;
   assign cmd_bus.cmd_wdata = cmd_wdata_q;

   // ---------------------------------------------------------------------------------------
   // Status: busy, LED byte, sticky error
   // ---------------------------------------------------------------------------------------
   logic       busy_q;
   logic [7:0] led_q, led_d;
   logic       err_q, err_d;

   // A failed response only sets the error flag. Only an OKAY read updates the LEDs.
   always_comb begin
      led_d = led_q;
      err_d = err_q;
      if (resp_take) begin
         if (cmd_bus.resp_code != RESP_OKAY) begin
            err_d = 1'b1;
         end else if (!cmd_write_q) begin
            led_d = cmd_bus.resp_rdata[7:0];
         end
      end
   end

   // Status registers. busy tracks the state the FSM is entering, so it matches state_q.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         busy_q <= 1'b0;
         led_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= (state_d != StIdle);
         led_q  <= led_d;
         err_q  <= err_d;
      end
   end

   assign busy       = busy_q;
   assign led_data   = led_q;
   assign err_sticky = err_q;

endmodule

// File: tb/tb_axi_lite_cmd_launcher.sv
// Scoreboard bench for axi_lite_cmd_launcher with a short debounce window.
// The stimulus side pushes the expected command and the expected post-response status.
// A free-running monitor pops and compares them whenever the DUT presents a command or
// completes a response.
module tb_axi_lite_cmd_launcher;

   localparam int unsigned DC = 4;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          sw_enable = 1'b0;
   logic          sw_rw = 1'b0;
   logic [AW-1:0] sw_addr = '0;
   logic [DW-1:0] wr_data_in = '0;
   logic          busy;
   logic [7:0]    led_data;
   logic          err_sticky;

   always #5 aclk = ~aclk;

   axi_lite_cmd_launcher_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   axi_lite_cmd_launcher #(
      .DEBOUNCE_CYCLES (DC),
      .ADDR_W          (AW),
      .DATA_W          (DW)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .sw_enable  (sw_enable),
      .sw_rw      (sw_rw),
      .sw_addr    (sw_addr),
      .wr_data_in (wr_data_in),
      .cmd_bus    (bus),
      .busy       (busy),
      .led_data   (led_data),
      .err_sticky (err_sticky)
   );

   typedef struct packed {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   typedef struct packed {
      logic [7:0] led;
      logic       err;
   } st_t;

   cmd_t       exp_cmd_q[$];
   st_t        exp_st_q[$];
   int         total = 0;
   int         bad = 0;

   // Reference model: the LEDs show the last OKAY read byte, and any non-OKAY response sets
   // the error flag.
   logic [7:0] model_led = '0;
   logic       model_err = 1'b0;
   logic       cur_rw = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // ---------------------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------------------
   logic mon_in_wait = 1'b0;
   logic mon_chk_next = 1'b0;
   cmd_t mon_c;
   st_t  mon_s;

   initial begin : monitor
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            mon_in_wait  = 1'b0;
            mon_chk_next = 1'b0;
         end else begin
            if (mon_chk_next) begin
               mon_chk_next = 1'b0;
               if (exp_st_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL status_pop: got response with no expected status queued");
               end else begin
                  mon_s = exp_st_q.pop_front();
                  check("led_after_resp", DW'(led_data), DW'(mon_s.led));
                  check("err_after_resp", DW'(err_sticky), DW'(mon_s.err));
                  check("busy_after_resp", DW'(busy), '0);
               end
            end
            if (mon_in_wait && bus.resp_valid) begin
               mon_in_wait  = 1'b0;
               mon_chk_next = 1'b1;
            end
            if (bus.cmd_valid) begin
               if (exp_cmd_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_cmd: got cmd_valid=1 addr=%0h, want no command",
                           bus.cmd_addr);
               end else begin
                  mon_c = exp_cmd_q[0];
                  check("cmd_write", DW'(bus.cmd_write), DW'(mon_c.w));
                  check("cmd_addr", DW'(bus.cmd_addr), DW'(mon_c.a));
                  check("cmd_wdata", bus.cmd_wdata, mon_c.d);
                  if (bus.cmd_ready) begin
                     void'(exp_cmd_q.pop_front());
                     mon_in_wait = 1'b1;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------------------
   // Settle the enable low, set the switches, then raise the enable (optionally with
   // bounce). Wait a bounded time for cmd_valid.
   task automatic launch(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input bit bounce, input bit chk_lat);
      int  n;
      bit  found;
      cmd_t c;
      sw_enable = 1'b0;
      repeat (12) tick();
      sw_rw      = rw;
      sw_addr    = addr;
      wr_data_in = wd;
      cur_rw     = rw;
      c.w = rw;
      c.a = addr;
      c.d = wd;
      exp_cmd_q.push_back(c);
      if (bounce) begin
         sw_enable = 1'b1; tick();
         sw_enable = 1'b0; tick();
         sw_enable = 1'b1; tick();
         sw_enable = 1'b0; tick();
      end
      sw_enable = 1'b1;
      n = 0;
      found = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (bus.cmd_valid) begin
            n = i;
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL launch_timeout: got no cmd_valid in 30 cycles, want one");
      end else if (chk_lat) begin
         check("launch_latency", DW'(n), DW'(2 + DC + 1));
      end
   endtask

   // Act as the AXI-Lite master: accept after rdelay cycles, then return a response.
   task automatic serve(input int rdelay, input logic [1:0] code, input logic [DW-1:0] rdata,
                        input bit retoggle, input bit early_resp);
      st_t s;
      repeat (rdelay) tick();
      bus.cmd_ready = 1'b1;
      if (early_resp) begin
         bus.resp_valid = 1'b1;
         bus.resp_code  = 2'b10;
         bus.resp_rdata = $urandom;
      end
      tick();
      bus.cmd_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      check("cmd_valid_after_accept", DW'(bus.cmd_valid), '0);
      check("busy_in_wait", DW'(busy), DW'(1));
      if (retoggle) begin
         sw_enable = 1'b0;
         repeat (10) tick();
         sw_enable = 1'b1;
         repeat (10) tick();
         check("no_launch_in_wait", DW'(bus.cmd_valid), '0);
      end else begin
         repeat ($urandom_range(0, 3)) tick();
      end
      if (code != 2'b00) model_err = 1'b1;
      else if (!cur_rw) model_led = rdata[7:0];
      s.led = model_led;
      s.err = model_err;
      exp_st_q.push_back(s);
      bus.resp_valid = 1'b1;
      bus.resp_code  = code;
      bus.resp_rdata = rdata;
      tick();
      bus.resp_valid = 1'b0;
      bus.resp_code  = 2'($urandom_range(0, 3));
      bus.resp_rdata = $urandom;
      repeat (3) tick();
   endtask

   // ---------------------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------------------
   initial begin : stim
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [1:0]    code;
      bit            found;
      cmd_t          c;

      bus.cmd_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_code  = 2'b00;
      bus.resp_rdata = '0;

      repeat (3) @(posedge aclk);
      #1;
      check("rst_cmd_valid", DW'(bus.cmd_valid), '0);
      check("rst_busy", DW'(busy), '0);
      check("rst_led", DW'(led_data), '0);
      check("rst_err", DW'(err_sticky), '0);
      aresetn = 1'b1;
      repeat (4) tick();

      // Bounce before steady high, then a read.
      launch(1'b0, 5'h11, 32'h0BAD_F00D, 1'b1, 1'b1);
      serve(0, 2'b00, 32'h1234_5678, 1'b0, 1'b0);

      // Read from address 3 with a late ready.
      launch(1'b0, 5'h03, $urandom, 1'b0, 1'b1);
      serve(2, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check("led_deadbeef", DW'(led_data), DW'(8'hEF));

      // A write leaves the LEDs alone.
      launch(1'b1, 5'h1F, 32'hA5A5_0F0F, 1'b0, 1'b1);
      serve(0, 2'b00, 32'h0000_0099, 1'b0, 1'b0);
      check("led_after_write", DW'(led_data), DW'(8'hEF));

      // A response seen while IDLE is ignored.
      bus.resp_valid = 1'b1;
      bus.resp_code  = 2'b11;
      bus.resp_rdata = 32'h0000_0066;
      tick();
      bus.resp_valid = 1'b0;
      tick();
      check("idle_resp_err", DW'(err_sticky), DW'(model_err));
      check("idle_resp_led", DW'(led_data), DW'(model_led));

      // The enable is re-toggled during WAIT, which gives no second command.
      launch(1'b0, 5'h07, $urandom, 1'b0, 1'b1);
      serve(1, 2'b00, 32'h0000_0055, 1'b1, 1'b0);
      repeat (10) tick();
      check("idle_after_retoggle", DW'(busy), '0);
      check("no_cmd_after_retoggle", DW'(bus.cmd_valid), '0);

      // A response in the same cycle as the handshake is not taken.
      launch(1'b0, 5'h08, $urandom, 1'b0, 1'b1);
      serve(0, 2'b00, 32'h0000_0042, 1'b0, 1'b1);

      // Random transactions.
      for (int k = 0; k < 10; k++) begin
         rw   = 1'($urandom_range(0, 1));
         addr = AW'($urandom_range(0, 31));
         wd   = $urandom;
         code = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         launch(rw, addr, wd, 1'($urandom_range(0, 1)), 1'b1);
         serve($urandom_range(0, 3), code, $urandom, 1'b0, 1'b0);
      end

      // An error response followed by a good read.
      launch(1'b0, 5'h04, $urandom, 1'b0, 1'b1);
      serve(0, 2'b10, 32'h0000_00AA, 1'b0, 1'b0);
      check("err_set", DW'(err_sticky), DW'(1));
      launch(1'b0, 5'h05, $urandom, 1'b0, 1'b1);
      serve(1, 2'b00, 32'h0000_0033, 1'b0, 1'b0);
      check("err_still_set", DW'(err_sticky), DW'(1));
      check("led_after_good", DW'(led_data), DW'(8'h33));

      // Reset asserted during ISSUE.
      wd = 32'hC0DE_1234;
      launch(1'b1, 5'h0A, wd, 1'b0, 1'b1);
      #2 aresetn = 1'b0;
      #1;
      check("abort_cmd_valid", DW'(bus.cmd_valid), '0);
      check("abort_busy", DW'(busy), '0);
      check("abort_led", DW'(led_data), '0);
      check("abort_err", DW'(err_sticky), '0);
      check("abort_cmd_write", DW'(bus.cmd_write), '0);
      check("abort_cmd_addr", DW'(bus.cmd_addr), '0);
      check("abort_cmd_wdata", bus.cmd_wdata, '0);
      exp_cmd_q.delete();
      model_led = '0;
      model_err = 1'b0;
      repeat (3) @(posedge aclk);
      #3 aresetn = 1'b1;

      // The enable is still held high, so exactly one command follows the release.
      c.w = 1'b1;
      c.a = 5'h0A;
      c.d = wd;
      exp_cmd_q.push_back(c);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.cmd_valid) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL relaunch_timeout: got no cmd_valid after reset release, want one");
      end else begin
         serve(0, 2'b00, 32'h0000_0077, 1'b0, 1'b0);
      end

      repeat (10) tick();
      check("cmd_queue_drained", DW'(exp_cmd_q.size()), '0);
      check("status_queue_drained", DW'(exp_st_q.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
